// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity receiver.
package serial_parity_pkg;

  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR,
    STOP
  } rx_state_t;

endpackage

// File: rtl/parity_acc.sv
// Running XOR accumulator: clears on clr, toggles when en and d are both high.
module parity_acc
  import serial_parity_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic p
);

  logic p_d, p_q;

  always_comb begin
    p_d = p_q;
    if (clr) begin
      p_d = 1'b0;
    end else if (en && d) begin
      p_d = ~p_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= 1'b0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Strobed serial frame receiver: start, DATA_W bits LSB first, parity, stop.
// Define SERIAL_PARITY_RX_STOP_CHECK_EN to flag a low stop bit on frame_err.
module serial_parity_rx
  import serial_parity_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              sin_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
  localparam logic OddSel = (PARITY_ODD != 0);

  rx_state_t         state_d, state_q;
  logic [CntW-1:0]   count_d, count_q;
  logic [DATA_W-1:0] shreg_d, shreg_q;
  logic              par_bit_d, par_bit_q;
  logic [DATA_W-1:0] data_out_d, data_out_q;
  logic              data_valid_d, data_valid_q;
  logic              parity_err_d, parity_err_q;
  logic              frame_err_d, frame_err_q;

  logic acc_clr, acc_en, acc_p;

  // Accumulator is zeroed as the start bit is taken, then folds every data bit.
  assign acc_clr = sin_valid && (state_q == IDLE) && !sin;
  assign acc_en  = sin_valid && (state_q == DATA);

  parity_acc u_parity_acc (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (acc_en),
    .d   (sin),
    .p   (acc_p)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shreg_d      = shreg_q;
    par_bit_d    = par_bit_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    if (sin_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!sin) begin
            state_d = DATA;
            count_d = '0;
          end
        end
        DATA: begin
          for (int unsigned i = 0; i < DATA_W; i++) begin
            if (count_q == CntW'(i)) begin
              shreg_d[i] = sin;
            end
          end
          if (count_q == LastBit) begin
            state_d = PAR;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        PAR: begin
          par_bit_d = sin;
          state_d   = STOP;
        end
        STOP: begin
          // Only the finished word reaches data_out, never the shift register mid-frame.
          state_d      = IDLE;
          data_out_d   = shreg_q;
          data_valid_d = 1'b1;
          parity_err_d = acc_p ^ par_bit_q ^ OddSel;
`ifdef SERIAL_PARITY_RX_STOP_CHECK_EN
          frame_err_d  = !sin;
`else
          frame_err_d  = 1'b0;
`endif
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      shreg_q      <= '0;
      par_bit_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shreg_q      <= shreg_d;
      par_bit_q    <= par_bit_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench: an even-parity and an odd-parity receiver share one serial line.
module tb_serial_parity_rx;

`ifdef SERIAL_PARITY_RX_STOP_CHECK_EN
  localparam bit StopChk = 1'b1;
`else
  localparam bit StopChk = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       sin_valid;
  logic [7:0] dout_e, dout_o;
  logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int dv_cnt_e = 0;
  int dv_cnt_o = 0;
  int base_e, base_o;

  always #5 clk = ~clk;

  serial_parity_rx #(
    .DATA_W     (8),
    .PARITY_ODD (0)
  ) u_dut_even (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .data_out   (dout_e),
    .data_valid (dv_e),
    .parity_err (pe_e),
    .frame_err  (fe_e),
    .busy       (busy_e)
  );

  serial_parity_rx #(
    .DATA_W     (8),
    .PARITY_ODD (1)
  ) u_dut_odd (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .data_out   (dout_o),
    .data_valid (dv_o),
    .parity_err (pe_o),
    .frame_err  (fe_o),
    .busy       (busy_o)
  );

  // Count every cycle data_valid is high; a stretched pulse counts more than once.
  always @(negedge clk) begin
    if (dv_e) dv_cnt_e++;
    if (dv_o) dv_cnt_o++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit gap);
    int n;
    if (gap) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        @(negedge clk);
        sin_valid = 1'b0;
        sin       = ~b;
      end
    end
    @(negedge clk);
    sin       = b;
    sin_valid = 1'b1;
  endtask

  task automatic send_frame(input string tag, input logic [7:0] data, input logic par,
                            input logic stop, input bit gap, input logic exp_pe_e,
                            input logic exp_pe_o);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(data[i], gap);
    send_bit(par, gap);
    send_bit(stop, gap);
    @(posedge clk);
    #1;
    check_eq({tag, "_dv_e"},   32'(dv_e),   32'd1);
    check_eq({tag, "_dv_o"},   32'(dv_o),   32'd1);
    check_eq({tag, "_dout_e"}, 32'(dout_e), 32'(data));
    check_eq({tag, "_dout_o"}, 32'(dout_o), 32'(data));
    check_eq({tag, "_pe_e"},   32'(pe_e),   32'(exp_pe_e));
    check_eq({tag, "_pe_o"},   32'(pe_o),   32'(exp_pe_o));
    check_eq({tag, "_fe_e"},   32'(fe_e),   32'(StopChk & ~stop));
  endtask

  task automatic go_idle();
    @(negedge clk);
    sin_valid = 1'b0;
    sin       = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    sin       = 1'b1;
    sin_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_dout", 32'(dout_e), 32'd0);
    check_eq("rst_dv",   32'(dv_e),   32'd0);
    check_eq("rst_pe",   32'(pe_e),   32'd0);
    check_eq("rst_fe",   32'(fe_e),   32'd0);
    check_eq("rst_busy", 32'(busy_e), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // Idle-line samples must not start a frame.
    repeat (3) begin
      @(negedge clk);
      sin_valid = 1'b1;
      sin       = 1'b1;
    end
    @(negedge clk);
    sin_valid = 1'b0;
    check_eq("idle_busy", 32'(busy_e), 32'd0);

    // 0xA5 has four ones: parity 0 is good for even, bad for odd.
    base_e = dv_cnt_e;
    send_frame("a5_good", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    go_idle();
    check_eq("a5_good_pulses", 32'(dv_cnt_e - base_e), 32'd1);
    check_eq("a5_hold_dout",   32'(dout_e), 32'hA5);
    check_eq("a5_busy",        32'(busy_e), 32'd0);

    send_frame("a5_badpar", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    go_idle();
    check_eq("a5_hold_pe", 32'(pe_e), 32'd1);

    // 0x01 with parity 1 is good even parity; stop bit low.
    base_e = dv_cnt_e;
    send_frame("stop0", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    go_idle();
    check_eq("stop0_pulses", 32'(dv_cnt_e - base_e), 32'd1);

    // Abandon 0xFF after three data bits.
    base_e = dv_cnt_e;
    send_bit(1'b0, 1'b0);
    repeat (3) send_bit(1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_eq("mid_busy", 32'(busy_e), 32'd1);
    @(negedge clk);
    rst       = 1'b1;
    sin_valid = 1'b0;
    #1;
    check_eq("rst_mid_busy_e", 32'(busy_e), 32'd0);
    check_eq("rst_mid_busy_o", 32'(busy_o), 32'd0);
    check_eq("rst_mid_dout",   32'(dout_e), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_no_dv", 32'(dv_cnt_e - base_e), 32'd0);
    send_frame("post_rst_3c", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    go_idle();

    // Random strobe gaps between bits.
    base_e = dv_cnt_e;
    base_o = dv_cnt_o;
    send_frame("gaps_5a", 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    go_idle();
    check_eq("gaps_pulses_e", 32'(dv_cnt_e - base_e), 32'd1);
    check_eq("gaps_pulses_o", 32'(dv_cnt_o - base_o), 32'd1);

    // Back-to-back: 0x12 (two ones) par 1, 0x34 (three ones) par 0; both good odd parity.
    base_o = dv_cnt_o;
    send_frame("b2b_12", 8'h12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame("b2b_34", 8'h34, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    go_idle();
    check_eq("b2b_pulses_o", 32'(dv_cnt_o - base_o), 32'd2);
    check_eq("b2b_last_dout", 32'(dout_o), 32'h34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_parity_rx.md
SERIAL_PARITY_RX -- requirements
Module: serial_parity_rx

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the data bits per frame (legal range 1..32).
REQ-002 The module SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port sin, input, 1 bit: serial line data; the line idles at 1.
REQ-006 The module SHALL have port sin_valid, input, 1 bit: bit strobe; sin is sampled only in cycles where sin_valid=1.
REQ-007 The module SHALL have port data_out, output, DATA_W bits: the last received data word.
REQ-008 The module SHALL have port data_valid, output, 1 bit: a one-cycle pulse marking a completed frame.
REQ-009 The module SHALL have port parity_err, output, 1 bit: parity mismatch for the frame flagged by data_valid.
REQ-010 The module SHALL have port frame_err, output, 1 bit: bad stop bit for the frame flagged by data_valid.
REQ-011 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 Frame format SHALL be: start bit (0), DATA_W data bits LSB first, one parity bit, one stop bit (1).
REQ-013 The FSM SHALL have exactly four states: IDLE, DATA, PAR and STOP.
REQ-014 IDLE SHALL go to DATA on a sample with sin=0; a sample with sin=1 keeps IDLE.
REQ-015 DATA SHALL shift each sample into bit position [count], with count starting at 0, and SHALL go to PAR after sample DATA_W-1.
REQ-016 PAR SHALL capture the parity bit and go to STOP on the next sample.
REQ-017 STOP SHALL return to IDLE on the next sample.
REQ-018 In cycles with sin_valid=0, the state, count and accumulator SHALL all hold.
REQ-019 A running XOR accumulator SHALL be cleared on leaving IDLE and SHALL fold in each data bit.
REQ-020 parity_err SHALL be (acc XOR parity_bit XOR PARITY_ODD) != 0.
REQ-021 On the STOP sample, the outputs SHALL update at the next clock edge: data_out takes the new word, data_valid=1 for exactly one cycle, and parity_err and frame_err are valid in that same cycle.
REQ-022 Latency SHALL be one clock from the rising edge that samples the stop bit to data_valid high.
REQ-023 data_out, parity_err and frame_err SHALL hold their values until the next completed frame.
REQ-024 A start bit SHALL be accepted on the first valid sample after STOP, so back-to-back frames with no idle bits are received.
REQ-025 No partial word SHALL ever appear on data_out.

Reset
REQ-026 On rst=1, the module SHALL asynchronously go to IDLE with data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, count=0 and acc=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no data_valid pulse; reception SHALL restart at the next start bit after release.

Configuration
REQ-028 With macro SERIAL_PARITY_RX_STOP_CHECK_EN defined, frame_err SHALL be 1 when the sampled stop bit is 0.
REQ-029 Without SERIAL_PARITY_RX_STOP_CHECK_EN, frame_err SHALL be tied to 0, and the stop sample SHALL only complete the frame.

Structure
REQ-030 Shared package serial_parity_pkg SHALL hold the state enum type rx_state_t (IDLE, DATA, PAR, STOP) and the constant DEF_DATA_W=8.
REQ-031 The parity accumulator SHALL be the sub-module parity_acc, with inputs clk, rst, clr, en, d and output p, where p toggles on en&d.
REQ-032 The bit counter SHALL be $clog2(DATA_W)+1 bits wide, with no wrap-around beyond DATA_W-1.

Verification
REQ-033 The bench SHALL run this scenario: PARITY_ODD=0, frame 0xA5 with parity 0 and stop 1 -> data_out=0xA5, data_valid high for 1 cycle, parity_err=0, frame_err=0.
REQ-034 The bench SHALL run this scenario: frame 0xA5 with parity 1 -> data_out=0xA5, parity_err=1.
REQ-035 The bench SHALL run this scenario: frame 0x01 with stop 0 -> frame_err=1 with the macro defined, frame_err=0 without it, data_valid=1 in both builds.
REQ-036 The bench SHALL run this scenario: rst asserted after 3 data bits of frame 0xFF -> busy=0 and no data_valid; then frame 0x3C -> data_out=0x3C, parity_err=0.
REQ-037 The bench SHALL run this scenario: frame 0x5A with 0-3 random sin_valid=0 gaps between bits -> data_out=0x5A, exactly one data_valid pulse.
REQ-038 The bench SHALL run this scenario: back-to-back frames 0x12 then 0x34 with no idle bits, PARITY_ODD=1 -> two data_valid pulses, words 0x12 then 0x34, parity_err=0 for both.
